// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the load/store unit: access size/sign codes, FSM states, bus widths.
package riscv_mem_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] wdata;
    logic [BE_W-1:0] be;
  } store_lane_t;

  function automatic logic f3_legal(input logic [2:0] f3);
    return !((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
  endfunction

  // size is Funct3[1:0]: halfwords need addr[0]=0, words need addr[1:0]=0
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    case (size)
      2'b01:   mis = offset[0];
      2'b10:   mis = (offset != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_format.sv
// Combinational data formatting: load lane extraction/extension and store lane replication/byte enables.
module lsu_format
  import riscv_mem_pkg::*;
(
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_offset,
  input  logic [XLEN-1:0] ld_word,
  output logic [XLEN-1:0] ld_data,
  input  logic [1:0]      st_size,
  input  logic [1:0]      st_offset,
  input  logic [XLEN-1:0] st_value,
  output logic [XLEN-1:0] st_wdata,
  output logic [BE_W-1:0] st_be
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  store_lane_t lane;

  // load: pick the addressed lane, then sign- or zero-extend
  always_comb begin
    case (ld_offset)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = ld_offset[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data = '0;
    case (ld_funct3)
      F3_B:    ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_H:    ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_W:    ld_data = ld_word;
      F3_BU:   ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      F3_HU:   ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = '0;
    endcase
  end

  // store: replicate the datum across every lane it could occupy
  always_comb begin
    lane = '0;
    case (st_size)
      2'b00: begin
        lane.wdata = {4{st_value[7:0]}};
        lane.be    = BE_W'(4'b0001 << st_offset);
      end
      2'b01: begin
        lane.wdata = {2{st_value[15:0]}};
        lane.be    = st_offset[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        lane.wdata = st_value;
        lane.be    = 4'b1111;
      end
      default: lane = '0;
    endcase
  end

  assign st_wdata = lane.wdata;
  assign st_be    = lane.be;

endmodule

// File: rtl/lsu_mem.sv
// Memory-stage load/store unit: stalls the pipeline while a single data-bus transaction completes or times out.
module lsu_mem
  import riscv_mem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic [2:0]      Funct3M,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ReadDataM,
  output logic            StallM,
  output logic            MisalignM,
  output logic            BusErrM,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [BE_W-1:0] dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata
);

  lsu_state_e       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [XLEN-1:0]  rdata_q;
  logic [2:0]       op_funct3;
  logic [1:0]       op_offset;
  logic             op_load;
  logic             bus_err_q;

  logic            legal;
  logic            misal;
  logic            issue;
  logic            timeout;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] st_wdata;
  logic [BE_W-1:0] st_be;

  assign legal   = (MemReadM || MemWriteM) && f3_legal(Funct3M);
  assign misal   = legal && is_misaligned(Funct3M[1:0], ALUResultM[1:0]);
  assign issue   = (state == ST_IDLE) && legal && !misal;
  assign timeout = (state == ST_BUSY) && !dmem_ack && (wait_cnt == CNT_W'(MAX_WAIT));

  lsu_format u_format (
    .ld_funct3 (op_funct3),
    .ld_offset (op_offset),
    .ld_word   (rdata_q),
    .ld_data   (ld_data),
    .st_size   (Funct3M[1:0]),
    .st_offset (ALUResultM[1:0]),
    .st_value  (WriteDataM),
    .st_wdata  (st_wdata),
    .st_be     (st_be)
  );

  // status outputs are forced low while reset is held
  assign StallM    = !reset && (issue || (state == ST_BUSY));
  assign MisalignM = !reset && (state == ST_IDLE) && misal;
  assign BusErrM   = !reset && (state == ST_DONE) && bus_err_q;
  assign ReadDataM = (!reset && (state == ST_DONE) && op_load && !bus_err_q) ? ld_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      rdata_q    <= '0;
      op_funct3  <= '0;
      op_offset  <= '0;
      op_load    <= 1'b0;
      bus_err_q  <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus_err_q <= 1'b0;
          if (issue) begin
            state      <= ST_BUSY;
            wait_cnt   <= '0;
            rdata_q    <= '0;
            op_funct3  <= Funct3M;
            op_offset  <= ALUResultM[1:0];
            op_load    <= !MemWriteM;
            dmem_req   <= 1'b1;
            dmem_we    <= MemWriteM;
            dmem_addr  <= {ALUResultM[XLEN-1:2], 2'b00};
            dmem_wdata <= MemWriteM ? st_wdata : '0;
            dmem_be    <= MemWriteM ? st_be : '0;
          end
        end
        ST_BUSY: begin
          // an ack arriving in the timeout cycle takes precedence
          if (dmem_ack || timeout) begin
            state      <= ST_DONE;
            bus_err_q  <= !dmem_ack;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
            if (dmem_ack) begin
              rdata_q <= dmem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          bus_err_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench for lsu_mem: expected load results are queued at issue and compared in the completion cycle.
module tb_lsu_mem;
  import riscv_mem_pkg::*;

  localparam int unsigned MAXW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignM, BusErrM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  always #5 clk = ~clk;

  lsu_mem #(.MAX_WAIT(MAXW)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .BusErrM    (BusErrM),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_be    (dmem_be),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata)
  );

  typedef struct {
    logic [31:0] rd;
    logic        berr;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {StallM, MisalignM, BusErrM, dmem_req, dmem_we, dmem_be}
  function automatic logic [31:0] flags();
    return 32'({StallM, MisalignM, BusErrM, dmem_req, dmem_we, dmem_be});
  endfunction

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    MemReadM   = rd;
    MemWriteM  = wr;
    Funct3M    = f3;
    ALUResultM = a;
    WriteDataM = wd;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, flags(), 32'd0);
    check({tag, "_rdata"}, ReadDataM, 32'd0);
    check({tag, "_addr"}, dmem_addr, 32'd0);
    check({tag, "_wdata"}, dmem_wdata, 32'd0);
  endtask

  // one full memory instruction; ack_at = BUSY-cycle index of the ack, -1 for none
  task automatic mem_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int ack_at,
                        input logic [31:0] rdata, input logic [31:0] exp_rd, input logic exp_berr,
                        output int n_busy, output int n_stall, output logic [31:0] bus_addr,
                        output logic [31:0] bus_wdata, output logic [4:0] bus_ctl);
    exp_t e;
    n_busy    = 0;
    n_stall   = 0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_ctl   = '0;
    e.rd      = exp_rd;
    e.berr    = exp_berr;
    @(negedge clk);
    drive(rd, wr, f3, a, wd);
    sb.push_back(e);
    #1;
    if (StallM) n_stall++;
    check({tag, "_issue_req"}, 32'(dmem_req), 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dmem_req !== 1'b1) break;
      dmem_ack   = (n_busy == ack_at);
      dmem_rdata = dmem_ack ? rdata : (32'hDEAD_BEEF ^ 32'(n_busy));
      #1;
      if (StallM) n_stall++;
      bus_addr  = dmem_addr;
      bus_wdata = dmem_wdata;
      bus_ctl   = {dmem_we, dmem_be};
      n_busy++;
    end
    // completion cycle; a stray ack here must not disturb the result
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h5555_5555;
    #1;
    check({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
    e = sb.pop_front();
    check({tag, "_rdata"}, ReadDataM, e.rd);
    check({tag, "_buserr"}, 32'(BusErrM), 32'(e.berr));
    check({tag, "_done_stall"}, 32'(StallM), 32'd0);
    drive(1'b0, 1'b0, F3_W, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    check({tag, "_after_flags"}, flags(), 32'd0);
    check({tag, "_after_rdata"}, ReadDataM, 32'd0);
    dmem_ack = 1'b0;
    @(negedge clk);
    #1;
    check({tag, "_idle_ack"}, flags(), 32'd0);
  endtask

  // access that must never reach the bus
  task automatic no_issue(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic exp_mis);
    logic [31:0] exp_flags;
    exp_flags = exp_mis ? 32'h0000_0080 : 32'h0;
    @(negedge clk);
    drive(rd, wr, f3, a, wd);
    #1;
    check({tag, "_flags"}, flags(), exp_flags);
    check({tag, "_rdata"}, ReadDataM, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check({tag, "_hold_flags"}, flags(), exp_flags);
    end
    drive(1'b0, 1'b0, F3_W, 32'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nb, ns;
    logic [31:0] ba, bw;
    logic [4:0]  bc;

    reset      = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    drive(1'b1, 1'b0, F3_W, 32'h100, 32'd0);
    @(negedge clk);
    #1;
    check_all_zero("rst_aligned");
    drive(1'b1, 1'b0, F3_W, 32'h101, 32'd0);
    #1;
    check_all_zero("rst_misaligned");
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, F3_W, 32'd0, 32'd0);
    #1;
    check_all_zero("post_rst");

    // loads
    mem_op("lb_neg", 1'b1, 1'b0, F3_B, 32'h103, 32'd0, 0, 32'h80FF_1234, 32'hFFFF_FF80, 1'b0,
           nb, ns, ba, bw, bc);
    check("lb_neg_busy", 32'(nb), 32'd1);
    check("lb_neg_stall", 32'(ns), 32'd2);
    check("lb_neg_addr", ba, 32'h0000_0100);
    check("lb_neg_ctl", 32'(bc), 32'd0);
    mem_op("lbu", 1'b1, 1'b0, F3_BU, 32'h103, 32'd0, 0, 32'h80FF_1234, 32'h0000_0080, 1'b0,
           nb, ns, ba, bw, bc);
    mem_op("lb_b1", 1'b1, 1'b0, F3_B, 32'h001, 32'd0, 0, 32'h80FF_1234, 32'h0000_0012, 1'b0,
           nb, ns, ba, bw, bc);
    check("lb_b1_addr", ba, 32'h0000_0000);
    mem_op("lh_hi", 1'b1, 1'b0, F3_H, 32'h102, 32'd0, 0, 32'h80FF_1234, 32'hFFFF_80FF, 1'b0,
           nb, ns, ba, bw, bc);
    mem_op("lhu_lo", 1'b1, 1'b0, F3_HU, 32'h000, 32'd0, 0, 32'h80FF_9234, 32'h0000_9234, 1'b0,
           nb, ns, ba, bw, bc);
    mem_op("lh_lo", 1'b1, 1'b0, F3_H, 32'h000, 32'd0, 0, 32'h80FF_9234, 32'hFFFF_9234, 1'b0,
           nb, ns, ba, bw, bc);
    mem_op("lw_wait", 1'b1, 1'b0, F3_W, 32'h104, 32'd0, 2, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0,
           nb, ns, ba, bw, bc);
    check("lw_wait_busy", 32'(nb), 32'd3);
    check("lw_wait_stall", 32'(ns), 32'd4);
    check("lw_wait_addr", ba, 32'h0000_0104);

    // stores
    mem_op("sh_hi", 1'b0, 1'b1, F3_H, 32'h202, 32'h0000_BEEF, 1, 32'h1234_5678, 32'd0, 1'b0,
           nb, ns, ba, bw, bc);
    check("sh_hi_busy", 32'(nb), 32'd2);
    check("sh_hi_addr", ba, 32'h0000_0200);
    check("sh_hi_wdata", bw, 32'hBEEF_BEEF);
    check("sh_hi_ctl", 32'(bc), 32'(5'b1_1100));
    mem_op("sb_b1", 1'b0, 1'b1, F3_B, 32'h301, 32'h0000_00A5, 0, 32'd0, 32'd0, 1'b0,
           nb, ns, ba, bw, bc);
    check("sb_b1_addr", ba, 32'h0000_0300);
    check("sb_b1_wdata", bw, 32'hA5A5_A5A5);
    check("sb_b1_ctl", 32'(bc), 32'(5'b1_0010));
    mem_op("sw", 1'b0, 1'b1, F3_W, 32'h400, 32'h1234_5678, 0, 32'd0, 32'd0, 1'b0,
           nb, ns, ba, bw, bc);
    check("sw_wdata", bw, 32'h1234_5678);
    check("sw_ctl", 32'(bc), 32'(5'b1_1111));
    mem_op("write_wins", 1'b1, 1'b1, F3_B, 32'h003, 32'h0000_003C, 0, 32'hFFFF_FFFF, 32'd0, 1'b0,
           nb, ns, ba, bw, bc);
    check("write_wins_wdata", bw, 32'h3C3C_3C3C);
    check("write_wins_ctl", 32'(bc), 32'(5'b1_1000));

    // accesses that must stay off the bus
    no_issue("lw_mis", 1'b1, 1'b0, F3_W, 32'h101, 32'd0, 1'b1);
    no_issue("lh_mis", 1'b1, 1'b0, F3_H, 32'h001, 32'd0, 1'b1);
    no_issue("sh_mis", 1'b0, 1'b1, F3_H, 32'h203, 32'hFFFF_FFFF, 1'b1);
    no_issue("sw_mis", 1'b0, 1'b1, F3_W, 32'h402, 32'hFFFF_FFFF, 1'b1);
    no_issue("f3_011", 1'b1, 1'b0, 3'b011, 32'h100, 32'd0, 1'b0);
    no_issue("f3_110", 1'b0, 1'b1, 3'b110, 32'h101, 32'd0, 1'b0);
    no_issue("no_access", 1'b0, 1'b0, F3_W, 32'h100, 32'd0, 1'b0);

    // bus timeout, then an ack landing exactly in the timeout cycle
    mem_op("lhu_tmo", 1'b1, 1'b0, F3_HU, 32'h000, 32'd0, -1, 32'd0, 32'd0, 1'b1,
           nb, ns, ba, bw, bc);
    check("lhu_tmo_busy", 32'(nb), 32'(MAXW + 1));
    check("lhu_tmo_stall", 32'(ns), 32'(MAXW + 2));
    mem_op("lhu_late", 1'b1, 1'b0, F3_HU, 32'h000, 32'd0, 4, 32'h1234_ABCD, 32'h0000_ABCD, 1'b0,
           nb, ns, ba, bw, bc);
    check("lhu_late_busy", 32'(nb), 32'(MAXW + 1));

    // reset in the second BUSY cycle abandons the transaction
    @(negedge clk);
    drive(1'b1, 1'b0, F3_W, 32'h500, 32'd0);
    #1;
    check("rb_issue_stall", 32'(StallM), 32'd1);
    @(negedge clk);
    #1;
    check("rb_busy1_req", 32'(dmem_req), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, F3_W, 32'd0, 32'd0);
    #1;
    check("rb_busy2_req", 32'(dmem_req), 32'd1);
    @(negedge clk);
    #1;
    check_all_zero("rb_in_reset");
    reset = 1'b0;
    @(negedge clk);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    #1;
    check_all_zero("rb_late_ack");
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    check_all_zero("rb_after_ack");
    @(negedge clk);
    #1;
    check_all_zero("rb_idle");

    mem_op("lw_recover", 1'b1, 1'b0, F3_W, 32'h600, 32'd0, 0, 32'h0102_0304, 32'h0102_0304, 1'b0,
           nb, ns, ba, bw, bc);
    check("lw_recover_addr", ba, 32'h0000_0600);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_mem.md
LSU_MEM -- requirements
Module: lsu_mem

Interface
REQ-001 Parameter: MAX_WAIT, 15, cycles in BUSY without dmem_ack before bus-error abort (1..255).
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 MemReadM  input  1  load in memory stage.
REQ-005 MemWriteM  input  1  store in memory stage; wins if both MemReadM and MemWriteM are high.
REQ-006 Funct3M  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 ALUResultM  input  32  byte address.
REQ-008 WriteDataM  input  32  store data, low-aligned.
REQ-009 ReadDataM  output  32  aligned, extended load data to the MEM/WB register.
REQ-010 StallM  output  1  freezes the fetch-through-memory stages and the MEM/WB register.
REQ-011 MisalignM  output  1  misaligned-access flag.
REQ-012 BusErrM  output  1  timeout flag.
REQ-013 dmem_req / dmem_we  output  1 each  bus request / write strobe.
REQ-014 dmem_addr  output  32  word address, bits [1:0] = 0.
REQ-015 dmem_wdata / dmem_be  output  32 / 4  lane-replicated store data / byte enables.
REQ-016 dmem_ack / dmem_rdata  input  1 / 32  completion / word read data, valid with ack.

Function
REQ-017 FSM states are IDLE, BUSY and DONE.
REQ-018 In IDLE with an aligned legal access, the block SHALL raise StallM combinationally, register the bus signals, and enter BUSY.
REQ-019 In BUSY, dmem_req=1 and StallM=1; the address, we, wdata and be registers SHALL stay stable until exit.
REQ-020 In BUSY with dmem_ack=1, the block SHALL capture dmem_rdata, drop dmem_req, and enter DONE.
REQ-021 In DONE, StallM=0 and ReadDataM = formatted captured data for loads, 0 for stores; the next state is IDLE.
REQ-022 The minimum occupancy of a memory instruction is 3 cycles (IDLE issue, BUSY with same-cycle ack, DONE).
REQ-023 Misalignment: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0, SHALL produce no request, MisalignM=1 combinationally in IDLE, StallM=0, ReadDataM=0, and no memory write.
REQ-024 Funct3M values 011, 110 and 111, or no access: stay in IDLE, no request, all flags 0, ReadDataM=0.
REQ-025 A wait counter SHALL be cleared on BUSY entry and increment each BUSY cycle without ack.
REQ-026 At count==MAX_WAIT without ack, the block SHALL drop dmem_req, enter DONE, set BusErrM=1 for that DONE cycle only, and force ReadDataM=0.
REQ-027 If dmem_ack arrives in the timeout cycle, the ack wins and BusErrM=0.
REQ-028 dmem_ack in IDLE or DONE SHALL be ignored.
REQ-029 Load extract: byte = rdata[8*a+7:8*a] with a=addr[1:0]; half = rdata[16*addr[1]+15:16*addr[1]]; B/H sign-extend; BU/HU zero-extend.
REQ-030 Store lanes: SB be=0001<<a with byte replicated x4; SH be=0011 or 1100 per addr[1] with half replicated x2; SW be=1111.
REQ-031 dmem_be=0000 for loads.

Reset
REQ-032 reset sampled high at a clk edge SHALL force IDLE, counter=0, captured data=0, and all bus registers to 0.
REQ-033 While in reset, all outputs SHALL be 0.
REQ-034 Reset during BUSY SHALL deassert dmem_req at that edge and abandon the transaction; a later ack is ignored per REQ-028.

Structure
REQ-035 Package riscv_mem_pkg SHALL hold the Funct3 size/sign encodings, the FSM state encoding, and XLEN=32.
REQ-036 One combinational sub-module, lsu_format, SHALL perform load extraction/extension and store lane/byte-enable generation.

Verification
REQ-037 LB at 0x103, ack same cycle as req, rdata=0x80FF_1234 -> DONE ReadDataM=0xFFFF_FF80; StallM high for exactly 2 cycles.
REQ-038 SH at 0x202, data 0x0000_BEEF -> dmem_addr=0x200, be=1100, wdata=0xBEEF_BEEF, we=1; ReadDataM=0.
REQ-039 LW at 0x101 -> MisalignM=1, dmem_req never asserted, StallM=0.
REQ-040 LHU at 0x0, MAX_WAIT=4, no ack -> req for 5 cycles, then BusErrM=1 for 1 cycle, ReadDataM=0; second run with ack at count 4 -> BusErrM=0.
REQ-041 reset pulsed in the 2nd BUSY cycle, then ack 2 cycles later -> req drops at the reset edge, the FSM stays in IDLE, and all outputs stay 0.
